lfsr_scan_display: RTL and testbench

Parametrised successor to the single-LFSR 7-segment demo top. It holds an N_DIGITS-nibble display bank, updates it on a slow tick according to a selectable mode (hold / LFSR load / scroll / count), and time-multiplexes the bank onto common-anode 7-segment digits. It sits directly under the board top, fed by switches and driving AN/SEG.

---
 rtl/lfsr_disp_pkg.sv | 40 ++++
 rtl/lfsr_scan_display_hex7seg.sv | 11 +
 rtl/lfsr_scan_display.sv | 123 ++++++++++++
 tb/tb_lfsr_scan_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_disp_pkg.sv
// Shared types and constants for the LFSR scan display: update modes,
// LFSR taps and the active-low hex-to-7-segment decode.
package lfsr_disp_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_SCROLL = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  function automatic logic [7:0] hex2seg(input logic [3:0] nibble);
    logic [7:0] pat;
    case (nibble)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/lfsr_scan_display_hex7seg.sv
// Combinational nibble to active-low 7-segment pattern (dp held off).
module hex7seg
  import lfsr_disp_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);

  assign o_seg = hex2seg(i_nib);

endmodule

// File: rtl/lfsr_scan_display.sv
// LFSR-fed display bank with tick-driven update modes, multiplexed onto
// common-anode 7-segment digits. Optional: BLANK_LEADING_ZEROS_EN.
module lfsr_scan_display
  import lfsr_disp_pkg::*;
#(
  parameter int unsigned        N_DIGITS   = 8,
  parameter int unsigned        LFSR_W     = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = 16'hACE1,
  parameter int unsigned        TICK_COUNT = 100_000_000,
  parameter int unsigned        SCAN_COUNT = 100_000
) (
  input  logic                  clk_100,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [1:0]            mode,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic [4*N_DIGITS-1:0] data_o,
  output logic                  tick_o
);

  localparam int unsigned BANK_W = 4 * N_DIGITS;
  localparam int unsigned TCNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int unsigned SCNT_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR16_TAPS);

  logic [LFSR_W-1:0]   r_lfsr;
  logic [BANK_W-1:0]   r_bank;
  logic [TCNT_W-1:0]   r_tick_cnt;
  logic [SCNT_W-1:0]   r_scan_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [N_DIGITS-1:0] r_an;
  logic [7:0]          r_seg;

  logic                w_fb;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic [BANK_W-1:0]   w_rep;
  logic [BANK_W-1:0]   w_scroll;
  logic [BANK_W-1:0]   w_bank_nxt;
  logic                w_scan_wrap;
  logic [3:0]          w_nib;
  logic [7:0]          w_seg_dec;
  logic [7:0]          w_seg_nxt;
  logic [N_DIGITS-1:0] w_an_nxt;

  assign w_fb       = ^(r_lfsr & TAPS);
  assign w_lfsr_nxt = (r_lfsr == '0) ? LFSR_SEED : {r_lfsr[LFSR_W-2:0], w_fb};

  assign tick_o      = (r_tick_cnt == TCNT_W'(TICK_COUNT - 1));
  assign w_scan_wrap = (r_scan_cnt == SCNT_W'(SCAN_COUNT - 1));

  always_comb begin
    w_rep = '0;
    for (int unsigned i = 0; i < BANK_W; i++) begin
      w_rep[i] = r_lfsr[i % LFSR_W];
    end
  end

  generate
    if (N_DIGITS > 1) begin : g_scroll_multi
      assign w_scroll = {r_bank[BANK_W-5:0], r_lfsr[3:0]};
    end else begin : g_scroll_single
      assign w_scroll = r_lfsr[3:0];
    end
  endgenerate

  always_comb begin
    w_bank_nxt = r_bank;
    if (tick_o && wr_en) begin
      case (mode_e'(mode))
        MODE_LOAD:   w_bank_nxt = w_rep;
        MODE_SCROLL: w_bank_nxt = w_scroll;
        MODE_COUNT:  w_bank_nxt = r_bank + BANK_W'(1);
        default:     w_bank_nxt = r_bank;
      endcase
    end
  end

  assign w_nib    = r_bank[4*r_idx +: 4];
  assign w_an_nxt = ~(N_DIGITS'(1) << r_idx);

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

`ifdef BLANK_LEADING_ZEROS_EN
  // Digit 0 is never blanked so an all-zero bank still shows a single "0".
  logic [BANK_W-1:0] w_upper;
  assign w_upper   = r_bank >> (4 * r_idx);
  assign w_seg_nxt = ((r_idx != '0) && (w_upper == '0)) ? SEG_BLANK : w_seg_dec;
`else
  assign w_seg_nxt = w_seg_dec;
`endif

  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      r_lfsr     <= LFSR_SEED;
      r_bank     <= '0;
      r_tick_cnt <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_an       <= '1;
      r_seg      <= SEG_BLANK;
    end else begin
      r_lfsr     <= w_lfsr_nxt;
      r_bank     <= w_bank_nxt;
      r_tick_cnt <= tick_o ? '0 : r_tick_cnt + TCNT_W'(1);
      r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SCNT_W'(1);
      if (w_scan_wrap) begin
        r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign an     = r_an;
  assign seg    = r_seg;
  assign data_o = r_bank;

endmodule

// File: tb/tb_lfsr_scan_display.sv
// Directed bench for lfsr_scan_display: reset, hold/gate, count, scroll/load
// against a reference LFSR, scan sequencing, async reset, and 2-digit wrap.
module tb_lfsr_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, wr_en2;
  logic [1:0]  mode, mode2;
  logic [7:0]  an, seg, an2_pad;
  logic [1:0]  an2;
  logic [7:0]  seg2;
  logic [31:0] data_o;
  logic [7:0]  data2;
  logic        tick_o, tick2;
  logic [15:0] m_lfsr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  lfsr_scan_display #(
    .N_DIGITS   (8),
    .LFSR_W     (16),
    .LFSR_SEED  (16'hACE1),
    .TICK_COUNT (20),
    .SCAN_COUNT (4)
  ) dut (
    .clk_100 (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .mode    (mode),
    .an      (an),
    .seg     (seg),
    .data_o  (data_o),
    .tick_o  (tick_o)
  );

  lfsr_scan_display #(
    .N_DIGITS   (2),
    .LFSR_W     (16),
    .LFSR_SEED  (16'hACE1),
    .TICK_COUNT (2),
    .SCAN_COUNT (2)
  ) dut2 (
    .clk_100 (clk),
    .reset   (reset),
    .wr_en   (wr_en2),
    .mode    (mode2),
    .an      (an2),
    .seg     (seg2),
    .data_o  (data2),
    .tick_o  (tick2)
  );

  assign an2_pad = {6'h3F, an2};

  // Reference Fibonacci LFSR, taps 16,14,13,11
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else if (m_lfsr == 16'h0) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o && n < 100);
    if (!tick_o) check_vec(tag, {31'b0, tick_o}, 32'd1);
  endtask

  task automatic tick_step(input string tag);
    wait_tick(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic measure_period(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o && n < 100);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] exp;
    logic [7:0]  exp_an, exp_seg;

    reset = 1'b0; wr_en = 1'b0; mode = 2'b00; wr_en2 = 1'b0; mode2 = 2'b00;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_vec("rst_an",   {24'b0, an},  32'hFF);
    check_vec("rst_seg",  {24'b0, seg}, 32'hFF);
    check_vec("rst_data", data_o,       32'h0);
    check_vec("rst_tick", {31'b0, tick_o}, 32'h0);

    reset = 1'b1;
    measure_period(n);
    check_vec("first_tick", n, 19);
    measure_period(n);
    check_vec("tick_period", n, 20);
    @(posedge clk); #1;

    wr_en = 1'b1; mode = 2'b00;
    repeat (3) tick_step("hold_tick");
    check_vec("hold", data_o, 32'h0);
    wr_en = 1'b0; mode = 2'b11;
    repeat (3) tick_step("gate_tick");
    check_vec("wr_gate", data_o, 32'h0);

    wr_en = 1'b1; mode = 2'b11;
    repeat (5) tick_step("count_tick");
    check_vec("count5", data_o, 32'h5);

    exp = 32'h5;
    mode = 2'b10;
    for (int i = 0; i < 8; i++) begin
      wait_tick("scroll_tick");
      exp = {exp[27:0], m_lfsr[3:0]};
      @(posedge clk); #1;
      check_vec("scroll", data_o, exp);
    end
    mode = 2'b01;
    for (int i = 0; i < 2; i++) begin
      wait_tick("load_tick");
      exp = {m_lfsr, m_lfsr};
      @(posedge clk); #1;
      check_vec("load", data_o, exp);
    end

    wr_en = 1'b0; mode = 2'b11;
    pulse_reset();
    wr_en = 1'b1;
    repeat (160) tick_step("scan_fill");
    wr_en = 1'b0;
    check_vec("bank_a0", data_o, 32'hA0);

    n = 0;
    while (an !== 8'h7F && n < 100) begin @(negedge clk); n++; end
    while (an !== 8'hFE && n < 100) begin @(negedge clk); n++; end
    check_vec("scan_sync", {24'b0, an}, 32'hFE);
    for (int k = 0; k < 32; k++) begin
      exp_an  = ~(8'h01 << (k / 4));
`ifdef BLANK_LEADING_ZEROS_EN
      exp_seg = (k / 4 == 1) ? 8'h88 : (k / 4 == 0) ? 8'hC0 : 8'hFF;
`else
      exp_seg = (k / 4 == 1) ? 8'h88 : 8'hC0;
`endif
      check_vec("scan_an",  {24'b0, an},  {24'b0, exp_an});
      check_vec("scan_seg", {24'b0, seg}, {24'b0, exp_seg});
      @(negedge clk);
    end

    pulse_reset();
    wr_en = 1'b1; mode = 2'b11;
    repeat (7) tick_step("ar_tick");
    check_vec("ar_count7", data_o, 32'h7);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_vec("ar_an",   {24'b0, an},  32'hFF);
    check_vec("ar_seg",  {24'b0, seg}, 32'hFF);
    check_vec("ar_data", data_o,       32'h0);
    check_vec("ar_tick", {31'b0, tick_o}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    measure_period(n);
    check_vec("ar_restart", n, 19);

    wr_en = 1'b0;
    pulse_reset();
    wr_en2 = 1'b1; mode2 = 2'b11;
    for (int t = 0; t < 256; t++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!tick2 && n < 10);
      if (!tick2) check_vec("d2_tick", {31'b0, tick2}, 32'd1);
      @(posedge clk); #1;
      if (t == 254) check_vec("d2_ff", {24'b0, data2}, 32'hFF);
    end
    check_vec("d2_wrap", {24'b0, data2}, 32'h00);
    check_vec("d2_an_onehot", {31'b0, (an2_pad == 8'hFE || an2_pad == 8'hFD)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
